mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory-bus slave port between two masters with the cpu-style request interface: addr, write_data, byte_enable, write_req, read_req, ready, read_data and read_data_valid.
- Typical use: master 0 is the cpu, master 1 is a DMA or debug master.
- Round-robin grant, one transaction per grant.
- Read responses return to the issuer in order, via an ID FIFO.

Parameters:
- READ_FIFO_DEPTH, 4, maximum accepted-but-unanswered reads. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_addr / m1_addr  in  32  request address.
- m0_write_data / m1_write_data  in  32  store data.
- m0_byte_enable / m1_byte_enable  in  4  byte lanes.
- m0_write_req / m1_write_req  in  1  write request, held until ready.
- m0_read_req / m1_read_req  in  1  read request, held until ready.
- m0_ready / m1_ready  out  1  request accepted this cycle.
- m0_read_data / m1_read_data  out  32  copy of s_read_data.
- m0_read_data_valid / m1_read_data_valid  out  1  response belongs to this master.
- s_addr, s_write_data  out  32  forwarded request fields.
- s_byte_enable  out  4  forwarded byte lanes.
- s_write_req, s_read_req  out  1  forwarded request strobes.
- s_ready  in  1  slave accepts the presented request this cycle.
- s_read_data  in  32  slave read data.
- s_read_data_valid  in  1  slave read response strobe.
- resp_error  out  1  sticky: a response arrived with no read outstanding.

Behaviour:
- State register takes one of three values: IDLE, GRANT_M0, GRANT_M1. A last_grant bit records the most recently served master.
- Reset (sync, takes priority over everything):
  - state=IDLE, last_grant=1 (so m0 wins the first tie).
  - ID FIFO emptied, resp_error=0.
  - Any transfer in flight is abandoned. Responses arriving after reset with an empty FIFO set resp_error.
- IDLE:
  - s_write_req=0, s_read_req=0; s_addr, s_write_data, s_byte_enable=0.
  - Both m*_ready=0.
  - Requesting master = write_req or read_req high.
  - Only one requesting: grant it. Both requesting: grant the one that is not last_grant.
  - Next state GRANT_Mx. Arbitration costs one cycle; at most one transaction per two cycles.
- GRANT_Mx:
  - s_* fields and request strobes are driven combinationally from master x.
  - blocked = mx_read_req && FIFO full. When blocked, s_read_req is forced to 0.
  - accept = s_ready && (mx_write_req || mx_read_req) && !blocked.
  - mx_ready = accept. The other master's ready=0.
  - On accept: next state IDLE, last_grant=x. If it was a read, push x into the FIFO.
  - Without accept: stay in GRANT_Mx. The grant never moves while a request is pending.
  - Master x dropping both requests without accept (illegal, but tolerated): return to IDLE, last_grant unchanged.
- Masters must not raise write_req and read_req together. If both are seen, both are forwarded unchanged and the access counts as a read for FIFO push.
- Responses:
  - m0_read_data = m1_read_data = s_read_data, combinationally.
  - mx_read_data_valid = s_read_data_valid && FIFO non-empty && head==x. On that cycle the FIFO pops.
  - s_read_data_valid with FIFO empty: dropped, resp_error set until reset.
- Push and pop in the same cycle, including when the FIFO is full: both occur and the count is unchanged. The full check for blocked uses the pre-pop count, which is conservative.
- FIFO pointers are log2(READ_FIFO_DEPTH) bits with natural wrap. The count is one bit wider.
- Zero-latency slaves: a response may arrive in the cycle after accept. A response in the accept cycle itself is illegal.

Decomposition:
- Shared package mem_bus_pkg holds:
  - master_id_t (1-bit);
  - constants MASTER_CPU=0 and MASTER_AUX=1;
  - arb_state_t (IDLE, GRANT_M0, GRANT_M1).
- One sub-module, resp_id_fifo: synchronous FIFO of master_id_t, depth READ_FIFO_DEPTH, with push, pop, head, full and empty.

Test Plan:
- Reset, then m0 reads 0x10000000 with s_ready=1. Expect s_read_req in cycle 2, m0_ready pulse in cycle 2. A response of 0x12345678 one cycle later raises only m0_read_data_valid.
- m0 and m1 hold writes continuously; m0 uses 0x100/data 0xAAAA, m1 uses 0x200/data 0xBBBB. Expect slave writes alternating m0, m1, m0, m1, and each master_ready to pulse once per 4 cycles.
- m1 write to 0x40 with s_ready low for 5 cycles. s_addr must stay 0x40 throughout. A m0 request arriving meanwhile is not granted until m1_ready pulses.
- Four m1 reads accepted with no responses (DEPTH=4). A fifth read shows s_read_req=0 and m1_ready=0. Once one response arrives, the fifth read is accepted on the next eligible cycle.
- Reads issued in order m0, m1, m0 with responses 0x1, 0x2, 0x3. Expect valids on m0, m1, m0 respectively, and the FIFO ends empty.
- s_read_data_valid pulsed with no reads outstanding sets resp_error=1. It stays 1 until reset is asserted for one cycle, after which it is 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter: master ids and arbiter states.
package mem_bus_pkg;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of master ids for outstanding reads; head names the owner of the next response.
module resp_id_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  output master_id_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  master_id_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory-bus slave between two masters, one transaction per grant,
// with read responses steered back to their issuer through an in-order id FIFO.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int READ_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic        m0_ready,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic        m1_ready,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_byte_enable,
  output logic        s_write_req,
  output logic        s_read_req,
  input  logic        s_ready,
  input  logic [31:0] s_read_data,
  input  logic        s_read_data_valid,
  output logic        resp_error,
  output logic [1:0]  dbg_state
);

  // Handshake: a master holds write_req/read_req with stable fields until it sees its ready
  // high in a cycle; that cycle is the transfer. The slave side is the same, with s_ready.

  arb_state_t state;
  arb_state_t state_next;
  master_id_t last_grant;
  master_id_t last_grant_next;

  logic       req0;
  logic       req1;
  master_id_t gnt_sel;
  logic       sel_wr;
  logic       sel_rd;
  logic       blocked;
  logic       accept;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  master_id_t fifo_head;

  assign req0    = m0_write_req | m0_read_req;
  assign req1    = m1_write_req | m1_read_req;
  assign gnt_sel = (state == GRANT_M1) ? MASTER_AUX : MASTER_CPU;
  assign sel_wr  = (gnt_sel == MASTER_AUX) ? m1_write_req : m0_write_req;
  assign sel_rd  = (gnt_sel == MASTER_AUX) ? m1_read_req  : m0_read_req;

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    s_addr          = '0;
    s_write_data    = '0;
    s_byte_enable   = '0;
    s_write_req     = 1'b0;
    s_read_req      = 1'b0;
    m0_ready        = 1'b0;
    m1_ready        = 1'b0;
    blocked         = 1'b0;
    accept          = 1'b0;
    fifo_push       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = (last_grant == MASTER_AUX) ? GRANT_M0 : GRANT_M1;
        end else if (req0) begin
          state_next = GRANT_M0;
        end else if (req1) begin
          state_next = GRANT_M1;
        end
      end
      GRANT_M0, GRANT_M1: begin
        s_addr        = (gnt_sel == MASTER_AUX) ? m1_addr        : m0_addr;
        s_write_data  = (gnt_sel == MASTER_AUX) ? m1_write_data  : m0_write_data;
        s_byte_enable = (gnt_sel == MASTER_AUX) ? m1_byte_enable : m0_byte_enable;
        // Full check uses the pre-pop count, so a read may wait one extra cycle.
        blocked       = sel_rd && fifo_full;
        s_write_req   = sel_wr;
        s_read_req    = sel_rd && !blocked;
        accept        = s_ready && (sel_wr || sel_rd) && !blocked;
        m0_ready      = accept && (gnt_sel == MASTER_CPU);
        m1_ready      = accept && (gnt_sel == MASTER_AUX);
        fifo_push     = accept && sel_rd;
        if (accept) begin
          state_next      = IDLE;
          last_grant_next = gnt_sel;
        end else if (!(sel_wr || sel_rd)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= MASTER_AUX;
      resp_error <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (s_read_data_valid && fifo_empty) begin
        resp_error <= 1'b1;
      end
    end
  end

  resp_id_fifo #(
    .DEPTH(READ_FIFO_DEPTH)
  ) u_resp_id_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifo_push),
    .push_id(gnt_sel),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Unsolicited responses are dropped; only resp_error records them.
  assign fifo_pop           = s_read_data_valid && !fifo_empty;
  assign m0_read_data_valid = fifo_pop && (fifo_head == MASTER_CPU);
  assign m1_read_data_valid = fifo_pop && (fifo_head == MASTER_AUX);
  assign m0_read_data       = s_read_data;
  assign m1_read_data       = s_read_data;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wd;
  logic [1:0][3:0]  m_be;
  logic [1:0]       m_wr;
  logic [1:0]       m_rd;
  wire  [1:0]       m_ready;
  wire  [1:0][31:0] m_rdata;
  wire  [1:0]       m_rvalid;
  wire  [31:0]      s_addr;
  wire  [31:0]      s_wd;
  wire  [3:0]       s_be;
  wire              s_wr;
  wire              s_rd;
  logic             s_ready;
  logic [31:0]      s_rdata;
  logic             s_rdv;
  wire              resp_error;
  wire  [1:0]       dbg_state;

  mem_bus_arbiter #(.READ_FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .m0_addr           (m_addr[0]),
    .m0_write_data     (m_wd[0]),
    .m0_byte_enable    (m_be[0]),
    .m0_write_req      (m_wr[0]),
    .m0_read_req       (m_rd[0]),
    .m0_ready          (m_ready[0]),
    .m0_read_data      (m_rdata[0]),
    .m0_read_data_valid(m_rvalid[0]),
    .m1_addr           (m_addr[1]),
    .m1_write_data     (m_wd[1]),
    .m1_byte_enable    (m_be[1]),
    .m1_write_req      (m_wr[1]),
    .m1_read_req       (m_rd[1]),
    .m1_ready          (m_ready[1]),
    .m1_read_data      (m_rdata[1]),
    .m1_read_data_valid(m_rvalid[1]),
    .s_addr            (s_addr),
    .s_write_data      (s_wd),
    .s_byte_enable     (s_be),
    .s_write_req       (s_wr),
    .s_read_req        (s_rd),
    .s_ready           (s_ready),
    .s_read_data       (s_rdata),
    .s_read_data_valid (s_rdv),
    .resp_error        (resp_error),
    .dbg_state         (dbg_state)
  );

  // scoreboard / reference model state
  int          n_cmp = 0;
  int          n_err = 0;
  int          owner;        // -1: nobody granted, else granted master
  int          last;         // most recently served master
  logic [0:0]  exp_q[$];     // ids of accepted, unanswered reads in issue order
  logic        err;
  logic [31:0] wlog[$];      // addresses of completed writes
  int          slave_out;    // reads the random slave still owes

  logic [1:0]  snap_rdy;
  logic [1:0]  snap_rvld;
  logic        snap_srd;
  logic        snap_err;
  logic [31:0] snap_addr;
  logic [31:0] snap_rdata0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven for this cycle; compare, advance the model, move to the next cycle.
  task automatic step();
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ew, er, blk, acc;
    logic [1:0]  erdy, evld;
    arb_state_t  est;
    int          x;
    #3;
    ea = '0; ed = '0; eb = '0; ew = 1'b0; er = 1'b0; blk = 1'b0; acc = 1'b0;
    erdy = '0; evld = '0; x = owner;
    est = (owner < 0) ? IDLE : ((owner == 0) ? GRANT_M0 : GRANT_M1);
    if (owner >= 0) begin
      ea   = m_addr[x];
      ed   = m_wd[x];
      eb   = m_be[x];
      ew   = m_wr[x];
      blk  = m_rd[x] && (exp_q.size() == DEPTH);
      er   = m_rd[x] && !blk;
      acc  = s_ready && (m_wr[x] || m_rd[x]) && !blk;
      erdy[x] = acc;
    end
    if (s_rdv && exp_q.size() > 0) evld[exp_q[0]] = 1'b1;

    check("slave_req", {s_addr, s_wd, s_be, s_wr, s_rd}, {ea, ed, eb, ew, er});
    check("ready", m_ready, erdy);
    check("rvalid", m_rvalid, evld);
    check("rdata", {m_rdata[1], m_rdata[0]}, {s_rdata, s_rdata});
    check("resp_error", resp_error, err);
    check("state", dbg_state, est);

    snap_rdy = m_ready; snap_rvld = m_rvalid; snap_srd = s_rd;
    snap_err = resp_error; snap_addr = s_addr; snap_rdata0 = m_rdata[0];

    if (s_rdv) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else err = 1'b1;
    end
    if (s_rd && s_ready) slave_out++;
    if (owner < 0) begin
      if ((m_wr[0] || m_rd[0]) && (m_wr[1] || m_rd[1])) owner = (last == 1) ? 0 : 1;
      else if (m_wr[0] || m_rd[0]) owner = 0;
      else if (m_wr[1] || m_rd[1]) owner = 1;
    end else if (acc) begin
      if (m_rd[x]) exp_q.push_back(1'(x));
      else wlog.push_back(m_addr[x]);
      last  = x;
      owner = -1;
    end else if (!(m_wr[x] || m_rd[x])) begin
      owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_wr = '0; m_rd = '0; s_ready = 1'b0; s_rdv = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    owner = -1; last = 1; exp_q.delete(); err = 1'b0; slave_out = 0;
  endtask

  // driver tasks
  task automatic issue_read(input int i, input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    m_rd[i] = 1'b1; m_addr[i] = a; s_ready = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = snap_rdy[i];
    end
    m_rd[i] = 1'b0;
    check("issue_done", ok, 1);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] exp_vld);
    s_rdv = 1'b1; s_rdata = d;
    step();
    check("rsp_vld", snap_rvld, exp_vld);
    check("rsp_data", snap_rdata0, d);
    s_rdv = 1'b0;
  endtask

  initial begin
    int         cnt0, cnt1, r;
    logic [1:0] pend;
    m_addr = '0; m_wd = '0; m_be = '0; s_rdata = '0;
    do_reset();

    // reset state
    step();
    check("rst_ready", snap_rdy, 2'b00);
    check("rst_err", snap_err, 1'b0);

    // single m0 read, response one cycle after accept
    m_rd[0] = 1'b1; m_addr[0] = 32'h1000_0000; m_be[0] = 4'hF; s_ready = 1'b1;
    step();
    check("t1_c1_srd", snap_srd, 1'b0);
    step();
    check("t1_c2_srd", snap_srd, 1'b1);
    check("t1_c2_rdy", snap_rdy, 2'b01);
    m_rd[0] = 1'b0;
    respond(32'h1234_5678, 2'b01);

    // both masters hold writes: strict alternation starting with m0
    do_reset();
    m_wr = 2'b11; m_addr[0] = 32'h100; m_wd[0] = 32'hAAAA; m_addr[1] = 32'h200; m_wd[1] = 32'hBBBB;
    s_ready = 1'b1; wlog.delete(); cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      cnt0 += int'(snap_rdy[0]);
      cnt1 += int'(snap_rdy[1]);
    end
    check("t2_nwr", wlog.size(), 8);
    for (int i = 0; i < wlog.size(); i++)
      check("t2_order", wlog[i], (i % 2 == 0) ? 32'h100 : 32'h200);
    check("t2_cnt0", cnt0, 4);
    check("t2_cnt1", cnt1, 4);
    m_wr = '0;
    step();

    // m1 write stalled by slave; m0 must wait
    m_wr[1] = 1'b1; m_addr[1] = 32'h40; m_wd[1] = 32'h1234; s_ready = 1'b0;
    step();
    m_rd[0] = 1'b1; m_addr[0] = 32'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_addr", snap_addr, 32'h40);
      check("t3_rdy", snap_rdy, 2'b00);
    end
    s_ready = 1'b1;
    step();
    check("t3_m1_rdy", snap_rdy, 2'b10);
    m_wr[1] = 1'b0;
    step();
    step();
    check("t3_m0_rdy", snap_rdy, 2'b01);
    m_rd[0] = 1'b0; s_ready = 1'b0;
    respond(32'hCAFE_0001, 2'b01);

    // FIFO full blocks the fifth read
    do_reset();
    m_rd[1] = 1'b1; m_addr[1] = 32'h300; s_ready = 1'b1; cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      cnt1 += int'(snap_rdy[1]);
    end
    check("t4_accepted", cnt1, 4);
    check("t4_blk_srd", snap_srd, 1'b0);
    check("t4_blk_rdy", snap_rdy, 2'b00);
    s_rdv = 1'b1; s_rdata = 32'h55;
    step();
    check("t4_pop_vld", snap_rvld, 2'b10);
    check("t4_pop_rdy", snap_rdy, 2'b00);
    s_rdv = 1'b0;
    step();
    check("t4_fifth_rdy", snap_rdy, 2'b10);
    m_rd[1] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) respond(32'h60 + 32'(i), 2'b10);

    // in-order steering m0, m1, m0
    issue_read(0, 32'hA0);
    issue_read(1, 32'hB0);
    issue_read(0, 32'hC0);
    s_ready = 1'b0;
    respond(32'h1, 2'b01);
    respond(32'h2, 2'b10);
    respond(32'h3, 2'b01);

    // unsolicited response sets sticky resp_error
    s_rdv = 1'b1; s_rdata = 32'hDEAD;
    step();
    check("t6_drop_vld", snap_rvld, 2'b00);
    s_rdv = 1'b0;
    step();
    check("t6_err_set", snap_err, 1'b1);
    step();
    check("t6_err_hold", snap_err, 1'b1);
    do_reset();
    step();
    check("t6_err_clr", snap_err, 1'b0);

    // random traffic
    pend = '0;
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && snap_rdy[i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          r = $urandom_range(0, 7);
          m_wr[i]   = (r == 2 || r == 3 || r == 6);
          m_rd[i]   = (r == 4 || r == 5 || r == 6);
          m_addr[i] = $urandom;
          m_wd[i]   = $urandom;
          m_be[i]   = 4'($urandom_range(0, 15));
          pend[i]   = m_wr[i] | m_rd[i];
        end
      end
      s_ready = ($urandom_range(0, 3) != 0);
      s_rdv   = (slave_out > 0) && ($urandom_range(0, 99) < ((c < 800) ? 20 : 70));
      if (s_rdv) slave_out--;
      s_rdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
